// File: rtl/log2_arbiter.sv
// Round-robin front end sharing one pipelined log2 unit between NUM_REQ requesters.
// Optional macro LOG2_ARB_CLAMP_EN: operands below 0x000100 are driven to the unit as 0x000100.
module log2_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LAT     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [24*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      res_valid,
  output logic [12*NUM_REQ-1:0]   res_data,
  output logic [NUM_REQ-1:0]      res_err,
  output logic [23:0]             log_din,
  input  logic [11:0]             log_dout
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDXW-1:0]       r_ptr;
  logic                  w_found;
  logic [IDXW-1:0]       w_gidx;
  logic [IDXW-1:0]       w_idx;
  logic [23:0]           w_opnd;
  logic [23:0]           w_din;
  logic                  w_err;

  logic [LAT-1:0]        r_tv;
  logic [LAT-1:0]        r_te;
  logic [IDXW-1:0]       r_ti [LAT];

  logic [NUM_REQ-1:0]    r_res_valid;
  logic [NUM_REQ-1:0]    r_res_err;
  logic [12*NUM_REQ-1:0] r_res_data;

  // Search starts one past the last granted index; reset masks every grant.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDXW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    if (reset) begin
      w_found = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_found) begin
      req_ready[w_gidx] = 1'b1;
    end
  end

  always_comb begin
    w_opnd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_gidx == IDXW'(i))) begin
        w_opnd = req_data[24*i +: 24];
      end
    end
    w_err = (w_opnd[23:8] == 16'h0000);
    w_din = w_opnd;
`ifdef LOG2_ARB_CLAMP_EN
    if (w_found && w_err) begin
      w_din = 24'h000100;
    end
`else
`endif
  end

  assign log_din = w_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= IDXW'(NUM_REQ - 1);
    end else if (w_found) begin
      r_ptr <= w_gidx;
    end
  end

  // Only the valid bits need reset; index/err are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tv <= '0;
    end else begin
      r_tv[0] <= w_found;
      for (int unsigned s = 1; s < LAT; s++) begin
        r_tv[s] <= r_tv[s-1];
      end
    end
    r_ti[0] <= w_gidx;
    r_te[0] <= w_err;
    for (int unsigned s = 1; s < LAT; s++) begin
      r_ti[s] <= r_ti[s-1];
      r_te[s] <= r_te[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= '0;
      r_res_err   <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= '0;
      r_res_err   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (r_tv[LAT-1] && (r_ti[LAT-1] == IDXW'(i))) begin
          r_res_valid[i]         <= 1'b1;
          r_res_err[i]           <= r_te[LAT-1];
          r_res_data[12*i +: 12] <= log_dout;
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_err   = r_res_err;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_log2_arbiter.sv
// Bench for log2_arbiter: stand-in log unit plus a round-robin/scoreboard reference model.
module tb_log2_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [24*N-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      res_valid;
  logic [12*N-1:0]   res_data;
  logic [N-1:0]      res_err;
  logic [23:0]       log_din;
  logic [11:0]       log_dout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          due;
    int          idx;
    logic [11:0] data;
    logic        err;
  } ret_t;

  ret_t            sb[$];
  int              m_ptr = N - 1;
  int              cyc   = 0;
  logic [12*N-1:0] m_rd  = '0;

  log2_arbiter #(.NUM_REQ(N), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .log_din(log_din), .log_dout(log_dout)
  );

  always #5 clk = ~clk;

  // Stand-in log unit: 8 fractional output bits, linear mantissa, top input saturates to 0xFFD.
  function automatic logic [11:0] ufn(input logic [23:0] x);
    int          m;
    logic [23:0] s;
    if (x == 24'hFFFFFF) return 12'hFFD;
    if (x < 24'h000100) return {4'hE, x[7:0]};
    m = 23;
    while (m > 8 && !x[m]) m--;
    s = x << (23 - m);
    return {4'(m - 8), s[22:15]};
  endfunction

  logic [11:0] u0 = 12'hA5A, u1 = 12'h5A5, u2 = 12'hBAD;
  always @(posedge clk) begin
    u0 <= ufn(log_din);
    u1 <= u0;
    u2 <= u1;
  end
  assign log_dout = u2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rnd_op();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 24'($urandom_range(0, 255));
    if (r == 1) return 24'h000100;
    if (r == 2) return 24'hFFFFFF;
    return 24'($urandom_range(32'h100, 32'hFFFFFF));
  endfunction

  function automatic logic [24*N-1:0] rnd_bus();
    logic [24*N-1:0] d;
    for (int i = 0; i < N; i++) d[i*24 +: 24] = rnd_op();
    return d;
  endfunction

  // One clock cycle: entered and left at a falling edge.
  task automatic cycle(input bit rst, input logic [N-1:0] v, input logic [24*N-1:0] d);
    logic [N-1:0] ev, ee, eg;
    logic [23:0]  raw, edin;
    ret_t         r, w;
    int           g, idx;
    ev = '0;
    ee = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      ev[r.idx] = 1'b1;
      ee[r.idx] = r.err;
      m_rd[r.idx*12 +: 12] = r.data;
    end
    check("res_valid", res_valid, ev);
    check("res_err", res_err, ee);
    check("res_data", res_data, m_rd);

    reset     = rst;
    req_valid = v;
    req_data  = d;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    eg   = '0;
    raw  = '0;
    edin = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      raw   = d[g*24 +: 24];
      edin  = raw;
`ifdef LOG2_ARB_CLAMP_EN
      if (raw < 24'h000100) edin = 24'h000100;
`endif
    end
    check("req_ready", req_ready, eg);
    check("log_din", log_din, edin);

    if (rst) begin
      sb.delete();
      m_rd  = '0;
      m_ptr = N - 1;
    end else if (g >= 0) begin
      w.due  = cyc + LAT + 1;
      w.idx  = g;
      w.data = ufn(edin);
      w.err  = (raw < 24'h000100);
      sb.push_back(w);
      m_ptr = g;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rnd_bus());
  endtask

  initial begin
    logic [11:0] small_exp;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);

    // reset state
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111, rnd_bus());

    // requester 0 alone, lowest valid operand
    cycle(1'b0, 4'b0001, {72'h0, 24'h000100});
    idle(5);
    check("r0_min", res_data[11:0], 12'h000);

    // requester 1 back to back, 0x200 then 0xFFFFFF
    cycle(1'b0, 4'b0010, {48'h0, 24'h000200, 24'h0});
    cycle(1'b0, 4'b0010, {48'h0, 24'hFFFFFF, 24'h0});
    check("r1_first", res_data[23:12], 12'h000);
    idle(2);
    check("r1_mid", res_data[23:12], 12'h100);
    idle(3);
    check("r1_last", res_data[23:12], 12'hFFD);

    // all requesters held valid right after reset
    cycle(1'b1, '0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'b1111, rnd_bus());
    idle(5);

    // requesters 0 and 2 with ptr at 0, then 2 drops out
    cycle(1'b1, '0, '0);
    cycle(1'b0, 4'b0001, rnd_bus());
    cycle(1'b0, 4'b0101, rnd_bus());
    cycle(1'b0, 4'b0101, rnd_bus());
    cycle(1'b0, 4'b1101, rnd_bus());
    cycle(1'b0, 4'b1001, rnd_bus());
    cycle(1'b0, 4'b1001, rnd_bus());
    idle(5);

    // three in flight, then a one-cycle reset
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, rnd_bus());
    cycle(1'b1, 4'b1111, rnd_bus());
    idle(6);

    // requester 3, operand below range
    cycle(1'b0, 4'b1000, {24'h000050, 72'h0});
    idle(5);
`ifdef LOG2_ARB_CLAMP_EN
    small_exp = 12'h000;
`else
    small_exp = 12'hE50;
`endif
    check("r3_small", res_data[47:36], small_exp);

    // randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 99) == 0), 4'($urandom), rnd_bus());
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
